// File: rtl/matrix_arb.sv
// Round-robin arbiter sharing one constant 2x2 multiply block between two requesters,
// with a one-entry valid/ready result register and saturating per-requester counters.

module matrix (
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    output logic [31:0] y1,
    output logic [31:0] y2
);
    assign y1 = 32'd21 * x1 + 32'd39 * x2;
    assign y2 = 32'd11 * x1 + 32'd5 * x2;
endmodule

module matrix_arb #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_x1,
    input  logic [31:0]      req0_x2,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_x1,
    input  logic [31:0]      req1_x2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_y1,
    output logic [31:0]      out_y2,
    output logic             out_id,
    output logic [CNT_W-1:0] done_cnt0,
    output logic [CNT_W-1:0] done_cnt1,
    output logic             busy
);
    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    logic [0:0]  state_p0;
    logic        last_grant;
    logic [31:0] x1_p0;
    logic [31:0] x2_p0;
    logic        slot_free;
    logic        gnt0;
    logic        gnt1;
    logic        acc0;
    logic        acc1;
    logic        consume;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        if (&c)
            return c;
        return c + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    assign out_valid = (state_p0 == FULL);
    assign busy      = out_valid;
    assign slot_free = !out_valid || out_ready;
    assign consume   = out_valid && out_ready;

    // Grant depends only on valids and last_grant, never on operand data.
    assign gnt0 = req0_valid && (!req1_valid || last_grant);
    assign gnt1 = req1_valid && (!req0_valid || !last_grant);

    assign req0_ready = slot_free && gnt0;
    assign req1_ready = slot_free && gnt1;
    assign acc0       = req0_valid && req0_ready;
    assign acc1       = req1_valid && req1_ready;

    // Stage p0: captured operands feed the multiply block; results are read straight out.
    matrix u_matrix (
        .x1 (x1_p0),
        .x2 (x2_p0),
        .y1 (out_y1),
        .y2 (out_y2)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_p0   <= EMPTY;
            out_id     <= 1'b0;
            last_grant <= 1'b1;
            x1_p0      <= '0;
            x2_p0      <= '0;
        end else begin
            if (acc0 || acc1) begin
                x1_p0      <= acc1 ? req1_x1 : req0_x1;
                x2_p0      <= acc1 ? req1_x2 : req0_x2;
                out_id     <= acc1;
                last_grant <= acc1;
                state_p0   <= FULL;
            end else if (consume) begin
                state_p0   <= EMPTY;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_cnt0 <= '0;
            done_cnt1 <= '0;
        end else if (consume) begin
            if (out_id)
                done_cnt1 <= sat_inc(done_cnt1);
            else
                done_cnt0 <= sat_inc(done_cnt0);
        end
    end

endmodule

// File: tb/tb_matrix_arb.sv
// Directed-vector bench for matrix_arb: table of per-cycle vectors plus hand-written
// sequences for stall, asynchronous reset and counter saturation (CNT_W=2).

module tb_matrix_arb;
    logic        clk;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_x1, req0_x2, req1_x1, req1_x2;
    logic        out_valid, out_ready, out_id, busy;
    logic [31:0] out_y1, out_y2;
    logic [1:0]  done_cnt0, done_cnt1;

    int n_vec = 0;
    int n_err = 0;

    matrix_arb #(.CNT_W(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_x1    (req0_x1),
        .req0_x2    (req0_x2),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_x1    (req1_x1),
        .req1_x2    (req1_x2),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_y1     (out_y1),
        .out_y2     (out_y2),
        .out_id     (out_id),
        .done_cnt0  (done_cnt0),
        .done_cnt1  (done_cnt1),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v0;
        logic [31:0] x10;
        logic [31:0] x20;
        logic        v1;
        logic [31:0] x11;
        logic [31:0] x21;
        logic        ordy;
        logic        r0;
        logic        r1;
        logic        ev;
        logic [31:0] ey1;
        logic [31:0] ey2;
        logic        eid;
        logic [1:0]  ec0;
        logic [1:0]  ec1;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v0, input logic [31:0] a0, input logic [31:0] b0,
                         input logic v1, input logic [31:0] a1, input logic [31:0] b1,
                         input logic ordy);
        req0_valid = v0; req0_x1 = a0; req0_x2 = b0;
        req1_valid = v1; req1_x1 = a1; req1_x2 = b1;
        out_ready  = ordy;
    endtask

    task automatic do_reset();
        drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0]  = '{1, 3, 4, 1, 2, 3, 1, 1, 0, 1, 219, 53, 0, 0, 0};
        tbl[1]  = '{1, 3, 4, 1, 2, 3, 1, 0, 1, 1, 159, 37, 1, 1, 0};
        tbl[2]  = '{1, 3, 4, 1, 2, 3, 1, 1, 0, 1, 219, 53, 0, 1, 1};
        tbl[3]  = '{1, 3, 4, 1, 2, 3, 1, 0, 1, 1, 159, 37, 1, 2, 1};
        tbl[4]  = '{1, 32'hFFFFFFFF, 0, 0, 0, 0, 1, 1, 0, 1, 32'hFFFFFFEB, 32'hFFFFFFF5, 0, 2, 2};
        tbl[5]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hFFFFFFEB, 32'hFFFFFFF5, 0, 2, 2};
        tbl[6]  = '{0, 0, 0, 1, 0, 1, 0, 0, 0, 1, 32'hFFFFFFEB, 32'hFFFFFFF5, 0, 2, 2};
        tbl[7]  = '{0, 0, 0, 1, 0, 1, 1, 0, 1, 1, 39, 5, 1, 3, 2};
        tbl[8]  = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 3, 3};
        tbl[9]  = '{1, 1, 1, 0, 0, 0, 1, 1, 0, 1, 60, 16, 0, 3, 3};
        tbl[10] = '{1, 5, 0, 0, 0, 0, 1, 1, 0, 1, 105, 55, 0, 3, 3};

        do_reset();
        chk("reset_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_y1", out_y1, 32'd0);
        chk("reset_cnt0", {30'd0, done_cnt0}, 32'd0);

        // Table: alternation, wrap, stall/resume, idle, saturation of cnt0.
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].v0, tbl[i].x10, tbl[i].x20, tbl[i].v1, tbl[i].x11, tbl[i].x21, tbl[i].ordy);
            #1;
            chk($sformatf("v%0d_rdy0", i), {31'd0, req0_ready}, {31'd0, tbl[i].r0});
            chk($sformatf("v%0d_rdy1", i), {31'd0, req1_ready}, {31'd0, tbl[i].r1});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].ev});
            chk($sformatf("v%0d_busy", i), {31'd0, busy}, {31'd0, tbl[i].ev});
            if (tbl[i].ev) begin
                chk($sformatf("v%0d_y1", i), out_y1, tbl[i].ey1);
                chk($sformatf("v%0d_y2", i), out_y2, tbl[i].ey2);
                chk($sformatf("v%0d_id", i), {31'd0, out_id}, {31'd0, tbl[i].eid});
            end
            chk($sformatf("v%0d_cnt0", i), {30'd0, done_cnt0}, {30'd0, tbl[i].ec0});
            chk($sformatf("v%0d_cnt1", i), {30'd0, done_cnt1}, {30'd0, tbl[i].ec1});
        end

        // Basic transaction then 5-cycle stall with both requesters pending.
        do_reset();
        drive(1'b1, 32'd1, 32'd1, 1'b0, '0, '0, 1'b1);
        #1;
        chk("first_rdy0", {31'd0, req0_ready}, 32'd1);
        @(posedge clk);
        #1;
        drive(1'b1, 32'd5, 32'd0, 1'b1, 32'd2, 32'd3, 1'b0);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("stall%0d_rdy", i), {30'd0, req1_ready, req0_ready}, 32'd0);
            chk($sformatf("stall%0d_y1", i), out_y1, 32'd60);
            chk($sformatf("stall%0d_y2", i), out_y2, 32'd16);
            chk($sformatf("stall%0d_id", i), {31'd0, out_id}, 32'd0);
            chk($sformatf("stall%0d_valid", i), {31'd0, out_valid}, 32'd1);
            @(posedge clk);
        end
        #1;
        out_ready = 1'b1;
        #1;
        chk("resume_rdy1", {31'd0, req1_ready}, 32'd1);
        chk("resume_rdy0", {31'd0, req0_ready}, 32'd0);
        @(posedge clk);
        #1;
        chk("resume_y1", out_y1, 32'd159);
        chk("resume_y2", out_y2, 32'd37);
        chk("resume_id", {31'd0, out_id}, 32'd1);
        chk("resume_cnt0", {30'd0, done_cnt0}, 32'd1);

        // Asynchronous reset between edges while FULL.
        drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_cnt0", {30'd0, done_cnt0}, 32'd0);
        chk("arst_y1", out_y1, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 32'd1, 32'd1, 1'b1, 32'd2, 32'd3, 1'b1);
        #1;
        chk("arst_grant0", {30'd0, req1_ready, req0_ready}, 32'd1);
        @(posedge clk);
        #1;
        chk("arst_id", {31'd0, out_id}, 32'd0);

        // Five requester-0 results consumed with a 2-bit counter.
        do_reset();
        drive(1'b1, 32'd1, 32'd1, 1'b0, '0, '0, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
        @(posedge clk);
        #1;
        chk("sat_cnt0", {30'd0, done_cnt0}, 32'd3);
        chk("sat_cnt1", {30'd0, done_cnt1}, 32'd0);
        chk("sat_valid", {31'd0, out_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1);
    end

endmodule
